// File: rtl/cpu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_sequencer : FETCH/EXEC1/EXEC2 phase sequencer and instruction register
// Rev 1.0
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int          CNT_W  = 16,
  parameter logic [15:0] IR_RST = 16'h7C00
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             STALL,
  input  logic [15:0]      RAMi_q,
  input  logic             E2,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [15:0]      instr,
  output logic             idle,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state;
  logic   step_latch;
  logic   is_stp;
  logic   stop_at_boundary;

  assign is_stp           = ~instr[15] & (instr[14:9] == 6'b111111);
  assign stop_at_boundary = step_latch | ~RUN;

  // Strobes are masked by STALL so downstream logic sees no phase while memory waits.
  assign FETCH  = (state == S_FETCH) & ~STALL;
  assign EXEC1  = (state == S_EXEC1) & ~STALL;
  assign EXEC2  = (state == S_EXEC2) & ~STALL;
  assign idle   = (state == S_IDLE);
  assign halted = (state == S_HALT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      step_latch  <= 1'b0;
      instr       <= IR_RST;
      instr_count <= '0;
    end else if (!STALL) begin
      case (state)
        S_IDLE: begin
          if (RUN) begin
            state <= S_FETCH;
          end else if (STEP) begin
            state      <= S_FETCH;
            step_latch <= 1'b1;
          end
        end
        S_FETCH: begin
          instr <= RAMi_q;
          state <= S_EXEC1;
        end
        S_EXEC1: begin
          if (is_stp) begin
            state       <= S_HALT;
            step_latch  <= 1'b0;
            instr_count <= instr_count + CNT_W'(1);
          end else if (E2) begin
            state <= S_EXEC2;
          end else begin
            state       <= stop_at_boundary ? S_IDLE : S_FETCH;
            step_latch  <= 1'b0;
            instr_count <= instr_count + CNT_W'(1);
          end
        end
        S_EXEC2: begin
          state       <= stop_at_boundary ? S_IDLE : S_FETCH;
          step_latch  <= 1'b0;
          instr_count <= instr_count + CNT_W'(1);
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// Bench for cpu_sequencer: fetched words are queued at FETCH and compared at EXEC1.
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b0;
  logic        STEP = 1'b0;
  logic        STALL = 1'b0;
  logic [15:0] RAMi_q = 16'h0000;
  logic        E2 = 1'b0;

  logic        FETCH, EXEC1, EXEC2, idle, halted;
  logic [15:0] instr;
  logic [15:0] instr_count;

  logic        f4, e14, e24, idle4, halt4;
  logic [15:0] instr4;
  logic [3:0]  count4;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 CLK = ~CLK;

  cpu_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .STALL(STALL),
    .RAMi_q(RAMi_q), .E2(E2), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2),
    .instr(instr), .idle(idle), .halted(halted), .instr_count(instr_count)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .STALL(STALL),
    .RAMi_q(RAMi_q), .E2(E2), .FETCH(f4), .EXEC1(e14), .EXEC2(e24),
    .instr(instr4), .idle(idle4), .halted(halt4), .instr_count(count4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobes_off(input string tag);
    chk(tag, {29'd0, FETCH, EXEC1, EXEC2}, 32'd0);
  endtask

  // Scoreboard: the word on RAMi_q during a FETCH strobe must appear on instr in EXEC1.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("onehot", 32'(FETCH) + 32'(EXEC1) + 32'(EXEC2) <= 1, 32'd1);
      if (FETCH) exp_q.push_back(RAMi_q);
      if (EXEC1) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("sb_instr", instr, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_idle", idle, 1);
    chk("rst_halted", halted, 0);
    chk("rst_instr", instr, 16'h7C00);
    chk("rst_count", instr_count, 0);
    strobes_off("rst_strobes");

    // Free run, single-cycle instructions
    @(posedge CLK); #1;
    RST = 1'b0; RUN = 1'b1; RAMi_q = 16'h0040;
    cyc(); chk("run_fetch", FETCH, 1);
    cyc(); chk("run_exec1", EXEC1, 1); chk("run_instr", instr, 16'h0040);
    cyc(); chk("run_cnt1", instr_count, 1); chk("run_fetch2", FETCH, 1);
    cyc(); chk("run_exec1b", EXEC1, 1);
    cyc(); chk("run_cnt2", instr_count, 2);

    // Two-cycle instruction, then pause at the boundary
    RAMi_q = 16'h0123; E2 = 1'b1;
    cyc(); chk("e2_exec1", EXEC1, 1);
    cyc(); chk("e2_exec2", EXEC2, 1); chk("e2_ir_stable", instr, 16'h0123);
    chk("e2_cnt_hold", instr_count, 2);
    cyc(); chk("e2_fetch", FETCH, 1); chk("e2_cnt3", instr_count, 3);
    E2 = 1'b0; RUN = 1'b0;
    cyc(); chk("drop_exec1", EXEC1, 1);
    cyc(); chk("drop_idle", idle, 1); chk("drop_cnt4", instr_count, 4);
    cyc(); chk("pause_idle", idle, 1); strobes_off("pause_strobes");

    // Single step, STEP during FETCH ignored
    STEP = 1'b1; RAMi_q = 16'h0201;
    cyc(); STEP = 1'b0; chk("step_fetch", FETCH, 1);
    STEP = 1'b1;
    cyc(); STEP = 1'b0; chk("step_exec1", EXEC1, 1);
    cyc(); chk("step_idle", idle, 1); chk("step_cnt5", instr_count, 5);
    cyc(); chk("step_noqueue", idle, 1); chk("step_cnt_hold", instr_count, 5);

    // Stall during FETCH
    RST = 1'b1; exp_q.delete(); #1;
    chk("rst2_instr", instr, 16'h7C00); chk("rst2_count", instr_count, 0);
    @(posedge CLK); #1;
    RST = 1'b0; RUN = 1'b1; RAMi_q = 16'h0055;
    cyc(); STALL = 1'b1; #1;
    chk("stall_mask", FETCH, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      strobes_off("stall_strobes");
      chk("stall_ir", instr, 16'h7C00);
    end
    STALL = 1'b0; #1;
    chk("stall_release", FETCH, 1);
    cyc(); chk("stall_exec1", EXEC1, 1); chk("stall_ir_load", instr, 16'h0055);
    cyc(); chk("stall_cnt", instr_count, 1);

    // STP halts
    RST = 1'b1; exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0; RUN = 1'b1; RAMi_q = 16'h7E00;
    cyc(); chk("stp_fetch", FETCH, 1);
    cyc(); chk("stp_exec1", EXEC1, 1);
    cyc(); chk("stp_halted", halted, 1); chk("stp_cnt", instr_count, 1);
    for (int i = 0; i < 6; i++) begin
      RUN = i[0]; STEP = ~i[0]; RAMi_q = 16'h0040;
      cyc();
      strobes_off("halt_strobes");
      chk("halt_sticky", halted, 1);
      chk("halt_cnt", instr_count, 1);
    end
    STEP = 1'b0; RST = 1'b1; exp_q.delete(); #1;
    chk("halt_rst_idle", idle, 1); chk("halt_rst_halted", halted, 0);

    // Counter wrap on the 4-bit instance, then async reset mid-EXEC1
    @(posedge CLK); #1;
    RST = 1'b0; RUN = 1'b1; E2 = 1'b0; RAMi_q = 16'h0040;
    for (int i = 0; i < 31; i++) cyc();
    chk("wrap_cnt15", count4, 15);
    cyc(); cyc();
    chk("wrap_cnt0", count4, 0);
    chk("wrap_cnt16", instr_count, 16);
    cyc(); chk("mid_exec1", EXEC1, 1);
    RST = 1'b1; exp_q.delete(); #1;
    chk("async_idle", idle, 1);
    chk("async_cnt", instr_count, 0);
    chk("async_cnt4", count4, 0);
    strobes_off("async_strobes");
    @(posedge CLK); #1;
    RST = 1'b0; RUN = 1'b0;
    cyc(); chk("post_rst_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
